// File: rtl/rice_bit_parser.sv
`default_nettype none
// ============================================================================
//  Module      : rice_bit_parser
//  Description : Serial front end of a Rice residual decoder. Counts the
//                unary prefix (run of 0s terminated by a 1 stop bit), then
//                shifts in k remainder bits, and presents each completed
//                code as (quotient, remainder) with a one-cycle valid pulse.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    iClock      in   1   clock, rising edge
//    iNReset     in   1   asynchronous active-low reset
//    iEnable     in   1   iBit is consumed only when high
//    iBit        in   1   serial bitstream, first-transmitted bit first
//    iRiceParam  in   4   Rice parameter k, sampled at each stop bit
//    oMSB        out 16   unary quotient of the last completed code
//    oLSB        out 16   k-bit remainder of the last code, zero-extended
//    oValid      out  1   one-cycle pulse marking a newly completed code
//    oOverflow   out  1   sticky: the unary count saturated (reset clears)
//    oCount      out 16   completed-code counter, wraps (only when the
//                         RICE_BIT_PARSER_STATS_EN macro is defined)
// ----------------------------------------------------------------------------
//  Build option
//    RICE_BIT_PARSER_STATS_EN : adds the oCount output and its counter.
// ============================================================================
module rice_bit_parser (
   input  logic        iClock,
   input  logic        iNReset,
   input  logic        iEnable,
   input  logic        iBit,
   input  logic [3:0]  iRiceParam,
   output logic [15:0] oMSB,
   output logic [15:0] oLSB,
   output logic        oValid,
   output logic        oOverflow
`ifdef RICE_BIT_PARSER_STATS_EN
   ,
   output logic [15:0] oCount
`endif
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [0:0] S_MSB = 1'b0;   // counting unary prefix
   localparam logic [0:0] S_LSB = 1'b1;   // shifting remainder bits

   localparam logic [15:0] C_QMAX = 16'hFFFF;

   logic [0:0]  r_state;
   logic [0:0]  w_state_next;

   // Quotient counter, remainder shifter, remaining-remainder-bit counter.
   // The bit counter is loaded with k at the stop bit, so it doubles as the
   // latched copy of k: later changes on iRiceParam cannot reach the code.
   logic [15:0] r_qcount;
   logic [15:0] r_shift;
   logic [3:0]  r_bitcnt;
   logic [15:0] r_msb;
   logic [15:0] r_lsb;
   logic        r_valid;
   logic        r_overflow;

   logic [15:0] w_qcount_next;
   logic [15:0] w_shift_next;
   logic [3:0]  w_bitcnt_next;
   logic [15:0] w_msb_next;
   logic [15:0] w_lsb_next;
   logic        w_valid_next;
   logic        w_overflow_next;

   // Remainder value after shifting in the current bit.
   logic [15:0] w_shift_in;
   assign w_shift_in = {r_shift[14:0], iBit};

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge iClock or negedge iNReset) begin
      if (!iNReset) begin
         r_state <= S_MSB;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      if (iEnable) begin
         case (r_state)
            S_MSB: begin
               // A stop bit with k=0 completes the code in place.
               if (iBit && (iRiceParam != 4'd0)) begin
                  w_state_next = S_LSB;
               end
            end
            S_LSB: begin
               if (r_bitcnt == 4'd1) begin
                  w_state_next = S_MSB;
               end
            end
            default: w_state_next = S_MSB;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FSM: output / datapath decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_qcount_next   = r_qcount;
      w_shift_next    = r_shift;
      w_bitcnt_next   = r_bitcnt;
      w_msb_next      = r_msb;
      w_lsb_next      = r_lsb;
      w_valid_next    = 1'b0;
      w_overflow_next = r_overflow;

      if (iEnable) begin
         case (r_state)
            S_MSB: begin
               if (!iBit) begin
                  // Saturating quotient; a zero arriving at the ceiling
                  // is lost and flagged instead.
                  if (r_qcount == C_QMAX) begin
                     w_overflow_next = 1'b1;
                  end else begin
                     w_qcount_next = r_qcount + 16'd1;
                  end
               end else if (iRiceParam == 4'd0) begin
                  w_msb_next    = r_qcount;
                  w_lsb_next    = 16'd0;
                  w_valid_next  = 1'b1;
                  w_qcount_next = 16'd0;
               end else begin
                  // Clearing the shifter keeps the remainder zero-extended.
                  w_shift_next  = 16'd0;
                  w_bitcnt_next = iRiceParam;
               end
            end
            S_LSB: begin
               w_shift_next  = w_shift_in;
               w_bitcnt_next = r_bitcnt - 4'd1;
               if (r_bitcnt == 4'd1) begin
                  w_msb_next    = r_qcount;
                  w_lsb_next    = w_shift_in;
                  w_valid_next  = 1'b1;
                  w_qcount_next = 16'd0;
               end
            end
            default: begin
               w_valid_next = 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge iClock or negedge iNReset) begin
      if (!iNReset) begin
         r_qcount   <= 16'd0;
         r_shift    <= 16'd0;
         r_bitcnt   <= 4'd0;
         r_msb      <= 16'd0;
         r_lsb      <= 16'd0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_qcount   <= w_qcount_next;
         r_shift    <= w_shift_next;
         r_bitcnt   <= w_bitcnt_next;
         r_msb      <= w_msb_next;
         r_lsb      <= w_lsb_next;
         r_valid    <= w_valid_next;
         r_overflow <= w_overflow_next;
      end
   end

   assign oMSB      = r_msb;
   assign oLSB      = r_lsb;
   assign oValid    = r_valid;
   assign oOverflow = r_overflow;

`ifdef RICE_BIT_PARSER_STATS_EN
   // ------------------------------------------------------------------------
   // Completed-code counter; advances on the same edge that raises oValid
   // so oCount already includes the code being presented.
   // ------------------------------------------------------------------------
   logic [15:0] r_count;

   always_ff @(posedge iClock or negedge iNReset) begin
      if (!iNReset) begin
         r_count <= 16'd0;
      end else if (w_valid_next) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign oCount = r_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rice_bit_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rice_bit_parser
//  Description : Self-checking bench for rice_bit_parser. Stimulus pushes
//                the expected (quotient, remainder, pulse cycle) into a
//                queue; an independent monitor pops and compares on every
//                oValid pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rice_bit_parser;

   logic        iClock;
   logic        iNReset;
   logic        iEnable;
   logic        iBit;
   logic [3:0]  iRiceParam;
   logic [15:0] oMSB;
   logic [15:0] oLSB;
   logic        oValid;
   logic        oOverflow;
`ifdef RICE_BIT_PARSER_STATS_EN
   logic [15:0] oCount;
`endif

   rice_bit_parser dut (
      .iClock     (iClock),
      .iNReset    (iNReset),
      .iEnable    (iEnable),
      .iBit       (iBit),
      .iRiceParam (iRiceParam),
      .oMSB       (oMSB),
      .oLSB       (oLSB),
      .oValid     (oValid),
      .oOverflow  (oOverflow)
`ifdef RICE_BIT_PARSER_STATS_EN
      ,
      .oCount     (oCount)
`endif
   );

   initial iClock = 1'b0;
   always #5 iClock = ~iClock;

   typedef struct packed {
      logic [15:0] msb;
      logic [15:0] lsb;
      logic [31:0] cyc;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] cyc = 0;
   int          pulses = 0;

   always @(posedge iClock) cyc <= cyc + 32'd1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every oValid pulse must match the oldest expected code,
   // including the cycle in which it appears.
   always @(negedge iClock) begin
      if (iNReset && oValid) begin
         pulses++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got pulse msb=%0h lsb=%0h at cyc %0d expected none",
                     oMSB, oLSB, cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("msb", {16'd0, oMSB}, {16'd0, e.msb});
            check("lsb", {16'd0, oLSB}, {16'd0, e.lsb});
            check("valid_cycle", cyc, e.cyc);
         end
      end
   end

   // Present one bit; it is consumed on the next rising edge.
   task automatic send_bit(input logic b, input logic [3:0] k);
      iEnable    = 1'b1;
      iBit       = b;
      iRiceParam = k;
      @(posedge iClock);
      #1;
      iEnable = 1'b0;
   endtask

   task automatic idle(input int n);
      iEnable = 1'b0;
      repeat (n) begin
         @(posedge iClock);
         #1;
      end
   endtask

   // Called right after the final bit's edge: the pulse is due in this cycle.
   task automatic expect_code(input logic [15:0] msb, input logic [15:0] lsb);
      exp_t e;
      e.msb = msb;
      e.lsb = lsb;
      e.cyc = cyc;
      sb_q.push_back(e);
   endtask

   initial begin
      iNReset    = 1'b0;
      iEnable    = 1'b0;
      iBit       = 1'b0;
      iRiceParam = 4'd0;
      #12;
      // Reset state
      check("rst_msb", {16'd0, oMSB}, 32'd0);
      check("rst_lsb", {16'd0, oLSB}, 32'd0);
      check("rst_valid", {31'd0, oValid}, 32'd0);
      check("rst_ovf", {31'd0, oOverflow}, 32'd0);
      iNReset = 1'b1;
      idle(2);

      // k=0: 0,0,1 -> (2,0)
      send_bit(1'b0, 4'd0);
      send_bit(1'b0, 4'd0);
      send_bit(1'b1, 4'd0);
      expect_code(16'd2, 16'd0);
      idle(3);

      // k=3 back-to-back: 0,1,110 -> (1,6); 1,011 -> (0,3), 4 cycles apart
      send_bit(1'b0, 4'd3);
      send_bit(1'b1, 4'd3);
      send_bit(1'b1, 4'd3);
      send_bit(1'b1, 4'd3);
      send_bit(1'b0, 4'd3);
      expect_code(16'd1, 16'd6);
      send_bit(1'b1, 4'd3);
      send_bit(1'b0, 4'd3);
      send_bit(1'b1, 4'd3);
      send_bit(1'b1, 4'd3);
      expect_code(16'd0, 16'd3);
      idle(3);
      // Outputs hold between pulses
      check("hold_msb", {16'd0, oMSB}, 32'd0);
      check("hold_lsb", {16'd0, oLSB}, 32'd3);

      // k=3 with an idle cycle after every bit: 25 zeros, 1, 011 -> (25,3).
      // iRiceParam is disturbed during the remainder bits.
      for (int i = 0; i < 25; i++) begin
         send_bit(1'b0, 4'd3);
         idle(1);
      end
      send_bit(1'b1, 4'd3);
      idle(1);
      send_bit(1'b0, 4'd7);
      idle(1);
      send_bit(1'b1, 4'd0);
      idle(1);
      send_bit(1'b1, 4'd15);
      expect_code(16'd25, 16'd3);
      idle(4);
      check("hold_msb25", {16'd0, oMSB}, 32'd25);

      // k changed 3 -> 0 after the stop bit: 1,101 -> (0,5)
      send_bit(1'b1, 4'd3);
      send_bit(1'b1, 4'd0);
      send_bit(1'b0, 4'd0);
      send_bit(1'b1, 4'd0);
      expect_code(16'd0, 16'd5);
      idle(3);

      // Reset mid-code: 0,0 then reset; afterwards 0,1 -> (1,0)
      send_bit(1'b0, 4'd0);
      send_bit(1'b0, 4'd0);
      iNReset = 1'b0;
      #1;
      check("async_rst_lsb", {16'd0, oLSB}, 32'd0);
      #10;
      iNReset = 1'b1;
      idle(1);
      send_bit(1'b0, 4'd0);
      send_bit(1'b1, 4'd0);
      expect_code(16'd1, 16'd0);
      idle(3);

      // Saturation: 65535 zeros reach the ceiling, the next sets overflow
      for (int i = 0; i < 65535; i++) send_bit(1'b0, 4'd0);
      check("ovf_not_yet", {31'd0, oOverflow}, 32'd0);
      send_bit(1'b0, 4'd0);
      check("ovf_set", {31'd0, oOverflow}, 32'd1);
      send_bit(1'b1, 4'd0);
      expect_code(16'hFFFF, 16'd0);
      idle(2);
      // Sticky across a further code
      send_bit(1'b1, 4'd0);
      expect_code(16'd0, 16'd0);
      idle(2);
      check("ovf_sticky", {31'd0, oOverflow}, 32'd1);
      iNReset = 1'b0;
      #1;
      check("ovf_rst", {31'd0, oOverflow}, 32'd0);
      check("msb_rst", {16'd0, oMSB}, 32'd0);
      #10;
      iNReset = 1'b1;
      idle(4);

      // All expected codes must have been seen
      check("pending_codes", sb_q.size(), 32'd0);
      check("pulse_total", pulses, 32'd8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
